target_controller: RTL and testbench

- PCI target (responder) controller: the other end of the bus from the initiator controller.
- Claims memory read/write transactions whose address falls in an 8-word window at BASE_ADDR.
- Asserts devsel/trdy, sources read data onto AD, and captures write data with byte-enable merge into an internal 8 x 32 memory.
- A local read port exposes the memory to the back-end.
- Bus signals frame, irdy, devsel and trdy are active-low, PCI style.

---
 rtl/target_controller.sv | 174 +++++++++++++++++
 tb/tb_target_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/target_controller.sv
// ---------------------------------------------------------------------------
// target_controller
//   PCI-style target (responder). Claims memory read/write transactions that
//   hit an 8-word window at BASE_ADDR, inserts optional initial wait states,
//   sources read data onto AD and merges write data into an 8 x 32 memory
//   under active-low byte enables. A local read port exposes the memory.
//
// Ports
//   clk       bus clock, all bus inputs sampled on the rising edge
//   rst       asynchronous active-high reset
//   AD        multiplexed address/data (driven only for read data)
//   C_BE      command in the address phase, active-low byte enables after
//   frame     active-low, high during a data phase marks the final phase
//   irdy      initiator ready, active-low
//   devsel    device select, active-low, z when not driven
//   trdy      target ready, active-low, z when not driven
//   loc_addr  local memory read index
//   loc_data  memory[loc_addr], combinational
// ---------------------------------------------------------------------------
module target_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] AD,
    input  logic [3:0]  C_BE,
    input  logic        frame,
    input  logic        irdy,
    output wire         devsel,
    output wire         trdy,
    input  logic [2:0]  loc_addr,
    output logic [31:0] loc_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        B_BUSY  = 2'd1,
        S_DATA  = 2'd2,
        TURN_AR = 2'd3
    } state_e;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;
    localparam logic [3:0] WAIT_W     = 4'(WAIT_CYCLES);

    state_e      state_q;
    logic [2:0]  idx_q;
    logic        rd_q;
    logic [3:0]  wcnt_q;
    logic        oe_q;        // devsel/trdy driven (S_DATA and TURN_AR)
    logic        devsel_q;
    logic        trdy_q;
    logic        ad_oe_q;     // read data on AD
    logic [31:0] mem_q [8];

    logic        cmd_rd;
    logic        cmd_wr;
    logic        addr_hit;
    logic        claim;
    logic [3:0]  wcnt_init;
    logic [3:0]  wcnt_d;
    logic [2:0]  idx_d;
    logic        xfer;
    logic        done;

    // Address-phase decode
    assign cmd_rd    = (C_BE == CMD_MEM_RD);
    assign cmd_wr    = (C_BE == CMD_MEM_WR);
    assign addr_hit  = (AD[31:5] == BASE_ADDR[31:5]);
    assign claim     = addr_hit && (cmd_rd || cmd_wr);
    // A read gets one extra cycle so the initiator can release AD first.
    assign wcnt_init = WAIT_W + {3'd0, cmd_rd};

    // Counter saturates at zero, so once the first transfer has happened
    // no further wait states are inserted.
    assign wcnt_d = (wcnt_q != 4'd0) ? (wcnt_q - 4'd1) : 4'd0;
    assign idx_d  = idx_q + 3'd1;

    assign xfer = (state_q == S_DATA) && !irdy && (wcnt_q == 4'd0);
    // Final transfer, or initiator gave up without a transfer.
    assign done = (xfer && frame) || (!xfer && frame && irdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            rd_q     <= 1'b0;
            wcnt_q   <= 4'd0;
            oe_q     <= 1'b0;
            devsel_q <= 1'b1;
            trdy_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!frame) begin
                        idx_q <= AD[4:2];
                        rd_q  <= cmd_rd;
                        if (claim) begin
                            state_q  <= S_DATA;
                            wcnt_q   <= wcnt_init;
                            oe_q     <= 1'b1;
                            devsel_q <= 1'b0;
                            trdy_q   <= (wcnt_init != 4'd0);
                            // wcnt_init > WAIT_W for reads: turnaround cycle
                            ad_oe_q  <= 1'b0;
                        end else begin
                            state_q  <= B_BUSY;
                        end
                    end
                end

                B_BUSY: begin
                    if (frame && irdy) begin
                        state_q <= IDLE;
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        idx_q <= idx_d;
                    end
                    if (done) begin
                        state_q  <= TURN_AR;
                        devsel_q <= 1'b1;
                        trdy_q   <= 1'b1;
                        ad_oe_q  <= 1'b0;
                    end else begin
                        wcnt_q   <= wcnt_d;
                        trdy_q   <= (wcnt_d != 4'd0);
                        ad_oe_q  <= rd_q && (wcnt_d <= WAIT_W);
                    end
                end

                TURN_AR: begin
                    state_q  <= IDLE;
                    oe_q     <= 1'b0;
                    devsel_q <= 1'b1;
                    trdy_q   <= 1'b1;
                    wcnt_q   <= 4'd0;
                end

                default: begin
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                    ad_oe_q <= 1'b0;
                end
            endcase
        end
    end

    // Write merge: only lanes with an active (low) byte enable change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (xfer && !rd_q) begin
            for (int b = 0; b < 4; b++) begin
                if (!C_BE[b]) begin
                    mem_q[idx_q][8*b +: 8] <= AD[8*b +: 8];
                end
            end
        end
    end

    assign devsel   = oe_q ? devsel_q : 1'bz;
    assign trdy     = oe_q ? trdy_q : 1'bz;
    // idx_q holds during initiator waits, so read data stays stable.
    assign AD       = ad_oe_q ? mem_q[idx_q] : 32'hzzzz_zzzz;
    assign loc_data = mem_q[loc_addr];

endmodule

// File: tb/tb_target_controller.sv
module tb_target_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame, irdy, ad_en, sel;
  logic [3:0]  cbe;
  logic [31:0] ad_drv;
  logic [2:0]  loc_addr;

  // Released bus lines float high, so "not driven" reads as all ones.
  tri1 [31:0] ad0, ad1;
  tri1        devsel0, trdy0, devsel1, trdy1;
  wire [31:0] loc0, loc1;
  wire        frame0, irdy0, frame1, irdy1;

  always #5 clk = ~clk;

  // Two targets on separate buses: u0 with no wait states, u1 with 2.
  // Only the selected one sees bus activity; the other sees an idle bus.
  assign frame0 = sel ? 1'b1 : frame;
  assign irdy0  = sel ? 1'b1 : irdy;
  assign frame1 = sel ? frame : 1'b1;
  assign irdy1  = sel ? irdy : 1'b1;
  assign ad0 = (ad_en && !sel) ? ad_drv : 32'hzzzz_zzzz;
  assign ad1 = (ad_en && sel) ? ad_drv : 32'hzzzz_zzzz;

  wire [31:0] ad_obs     = sel ? ad1 : ad0;
  wire        devsel_obs = sel ? devsel1 : devsel0;
  wire        trdy_obs   = sel ? trdy1 : trdy0;
  wire [31:0] loc_obs    = sel ? loc1 : loc0;

  target_controller #(.BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .AD(ad0), .C_BE(cbe), .frame(frame0), .irdy(irdy0),
    .devsel(devsel0), .trdy(trdy0), .loc_addr(loc_addr), .loc_data(loc0));

  target_controller #(.BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .AD(ad1), .C_BE(cbe), .frame(frame1), .irdy(irdy1),
    .devsel(devsel1), .trdy(trdy1), .loc_addr(loc_addr), .loc_data(loc1));

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [2][8];
  logic [31:0] rdq [$];
  logic [31:0] wd [8];
  logic [3:0]  wbe [8];
  int          iwait [8];

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        claim;
    logic [2:0]  chk_idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) mdl[s][i] = 32'd0;
  endtask

  // One complete transaction on the selected bus; n data phases.
  task automatic xact(input logic [3:0] cmd, input logic [31:0] addr, input int n,
                      input logic claim, input int lat);
    logic        rd;
    int          s, cur, cnt;
    logic [31:0] exp;
    rd  = (cmd == 4'b0110);
    s   = sel ? 1 : 0;
    cur = int'(addr[4:2]);
    rdq.delete();
    if (claim && rd)
      for (int k = 0; k < n; k++) rdq.push_back(mdl[s][(cur + k) % 8]);

    frame = 1'b0; irdy = 1'b1; cbe = cmd; ad_en = 1'b1; ad_drv = addr;
    step();

    if (!claim) begin
      chk("miss_devsel", 32'(devsel_obs), 32'd1);
      chk("miss_trdy", 32'(trdy_obs), 32'd1);
      frame = 1'b1; irdy = 1'b0; cbe = wbe[0]; ad_en = !rd; ad_drv = wd[0];
      for (int c = 0; c < 3; c++) begin
        step();
        chk("miss_devsel_dp", 32'(devsel_obs), 32'd1);
        chk("miss_trdy_dp", 32'(trdy_obs), 32'd1);
        if (rd) chk("miss_ad", ad_obs, 32'hFFFF_FFFF);
      end
      frame = 1'b1; irdy = 1'b1; ad_en = 1'b0;
      step();
      return;
    end

    chk("devsel_claim", 32'(devsel_obs), 32'd0);
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < iwait[k]; w++) begin
        frame = 1'b0; irdy = 1'b1; ad_en = 1'b0;
        if (rd && trdy_obs === 1'b0 && rdq.size() > 0) chk("ad_hold", ad_obs, rdq[0]);
        step();
      end
      frame = (k == n - 1); irdy = 1'b0;
      cbe = rd ? 4'h0 : wbe[k]; ad_en = !rd; ad_drv = wd[k];
      cnt = 0;
      while (trdy_obs !== 1'b0 && cnt < 20) begin
        step();
        cnt++;
      end
      if (cnt >= 20) begin
        chk("trdy_timeout", 32'(trdy_obs), 32'd0);
        break;
      end
      if (k == 0) chk("trdy_latency", 32'(cnt), 32'(lat));
      chk("devsel_data", 32'(devsel_obs), 32'd0);
      if (rd && rdq.size() > 0) begin
        exp = rdq.pop_front();
        chk("rd_data", ad_obs, exp);
      end
      step();
      if (!rd) begin
        for (int b = 0; b < 4; b++)
          if (!wbe[k][b]) mdl[s][cur][8*b +: 8] = wd[k][8*b +: 8];
        loc_addr = 3'(cur);
        #1;
        chk("loc_after_wr", loc_obs, mdl[s][cur]);
      end
      cur = (cur + 1) % 8;
    end

    frame = 1'b1; irdy = 1'b1; ad_en = 1'b0; cbe = 4'h0;
    #1;
    chk("turn_devsel", 32'(devsel_obs), 32'd1);
    chk("turn_trdy", 32'(trdy_obs), 32'd1);
    chk("turn_ad", ad_obs, 32'hFFFF_FFFF);
    step();
    chk("idle_devsel", 32'(devsel_obs), 32'd1);
    chk("idle_trdy", 32'(trdy_obs), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0111, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0000, 1'b1, 3'd2, 32'hDEAD_BEEF};
    vecs[1]  = '{4'b0111, 32'h0000_1004, 32'h1122_3344, 4'b0000, 1'b1, 3'd1, 32'h1122_3344};
    vecs[2]  = '{4'b0111, 32'h0000_1004, 32'hAABB_CCDD, 4'b1010, 1'b1, 3'd1, 32'h11BB_33DD};
    vecs[3]  = '{4'b0111, 32'h0000_2000, 32'h1234_5678, 4'b0000, 1'b0, 3'd0, 32'h0000_0000};
    vecs[4]  = '{4'b0010, 32'h0000_1000, 32'h5555_5555, 4'b0000, 1'b0, 3'd0, 32'h0000_0000};
    vecs[5]  = '{4'b0111, 32'h0000_101C, 32'hCAFE_F00D, 4'b0000, 1'b1, 3'd7, 32'hCAFE_F00D};
    vecs[6]  = '{4'b0111, 32'h0000_1018, 32'h0000_0006, 4'b0000, 1'b1, 3'd6, 32'h0000_0006};
    vecs[7]  = '{4'b0111, 32'h0000_1000, 32'h0000_000A, 4'b0000, 1'b1, 3'd0, 32'h0000_000A};
    vecs[8]  = '{4'b0111, 32'h0000_1004, 32'h0000_00FF, 4'b1110, 1'b1, 3'd1, 32'h11BB_33FF};
    vecs[9]  = '{4'b0111, 32'h0000_1FFC, 32'h9999_9999, 4'b0000, 1'b0, 3'd7, 32'hCAFE_F00D};
    vecs[10] = '{4'b0111, 32'h0000_0FE0, 32'h8888_8888, 4'b0000, 1'b0, 3'd0, 32'h0000_000A};
    vecs[11] = '{4'b0111, 32'h0000_101C, 32'h0000_0007, 4'b0000, 1'b1, 3'd7, 32'h0000_0007};

    for (int i = 0; i < 8; i++) begin wd[i] = 32'd0; wbe[i] = 4'h0; iwait[i] = 0; end
    clear_model();
    sel = 1'b0; frame = 1'b1; irdy = 1'b1; cbe = 4'h0; ad_en = 1'b0; ad_drv = 32'd0;
    loc_addr = 3'd0; rst = 1'b1;

    // Reset state
    @(posedge clk); @(negedge clk);
    chk("rst_devsel", 32'(devsel_obs), 32'd1);
    chk("rst_trdy", 32'(trdy_obs), 32'd1);
    chk("rst_ad", ad_obs, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      loc_addr = 3'(i);
      #1 chk("rst_mem", loc_obs, 32'd0);
    end
    rst = 1'b0;
    step();

    // Single-phase table, issued back to back
    for (int i = 0; i < 12; i++) begin
      wd[0] = vecs[i].data; wbe[0] = vecs[i].be;
      xact(vecs[i].cmd, vecs[i].addr, 1, vecs[i].claim, 0);
      loc_addr = vecs[i].chk_idx;
      #1 chk("vec_loc", loc_obs, vecs[i].exp);
    end

    // Read burst wrapping 6,7,0
    xact(4'b0110, 32'h0000_1018, 3, 1'b1, 1);
    // Read miss leaves AD alone
    xact(4'b0110, 32'h0000_2000, 1, 1'b0, 0);
    // Claimed normally after a miss
    xact(4'b0110, 32'h0000_1004, 1, 1'b1, 1);

    // Write burst wrapping 7 -> 0
    wd[0] = 32'h7777_0000; wd[1] = 32'h0000_AAAA; wbe[0] = 4'h0; wbe[1] = 4'h0;
    xact(4'b0111, 32'h0000_101C, 2, 1'b1, 0);
    loc_addr = 3'd0; #1 chk("wr_wrap_w0", loc_obs, 32'h0000_AAAA);

    // Reset in the middle of a write burst
    frame = 1'b0; irdy = 1'b1; cbe = 4'b0111; ad_en = 1'b1; ad_drv = 32'h0000_1000;
    step();
    frame = 1'b0; irdy = 1'b0; cbe = 4'h0; ad_drv = 32'h1234_5678;
    step();
    ad_drv = 32'h9ABC_DEF0;
    chk("mid_devsel", 32'(devsel_obs), 32'd0);
    loc_addr = 3'd0;
    #1 chk("mid_loc", loc_obs, 32'h1234_5678);
    #1 rst = 1'b1;
    #1;
    chk("arst_devsel", 32'(devsel_obs), 32'd1);
    chk("arst_trdy", 32'(trdy_obs), 32'd1);
    chk("arst_mem", loc_obs, 32'd0);
    frame = 1'b1; irdy = 1'b1; ad_en = 1'b0;
    #1;
    chk("arst_ad", ad_obs, 32'hFFFF_FFFF);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    wd[0] = 32'h0BAD_F00D; wbe[0] = 4'h0;
    xact(4'b0111, 32'h0000_1010, 1, 1'b1, 0);
    loc_addr = 3'd4; #1 chk("post_rst_wr", loc_obs, 32'h0BAD_F00D);

    // Wait-state target
    sel = 1'b1;
    step();
    wd[0] = 32'hA0A0_A0A0; xact(4'b0111, 32'h0000_1000, 1, 1'b1, 2);
    wd[0] = 32'hA1A1_A1A1; xact(4'b0111, 32'h0000_1004, 1, 1'b1, 2);
    wd[0] = 32'hA2A2_A2A2; xact(4'b0111, 32'h0000_1008, 1, 1'b1, 2);
    iwait[1] = 2;
    xact(4'b0110, 32'h0000_1000, 3, 1'b1, 3);
    iwait[1] = 0;
    loc_addr = 3'd2; #1 chk("w2_loc", loc_obs, 32'hA2A2_A2A2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
